// File: rtl/decoder_pipe_pkg.sv
// Shared types for the decoder pipe: decode modes and skid-buffer occupancy states.
// Used by all decoder_pipe files; parity option is DECODER_PIPE_PARITY_EN (see top).
package decoder_pkg;

  typedef enum logic [1:0] {
    MODE_ONEHOT = 2'b00,
    MODE_THERMO = 2'b01,
    MODE_INV    = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/decoder_pipe_if.sv
// Valid/ready bundle for decoder_pipe: input beat (sel, mode) and decoded output beat.
// Optional out_par appears when DECODER_PIPE_PARITY_EN is defined.
import decoder_pkg::*;

interface decoder_pipe_if #(
  parameter int SEL_W = 3,
  parameter int OUT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] in_sel;
  mode_t            in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_err;
`ifdef DECODER_PIPE_PARITY_EN
  logic             out_par;

  modport master (
    output in_valid, in_sel, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_err, out_par
  );
  modport slave (
    input  in_valid, in_sel, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_err, out_par
  );
`else
  modport master (
    output in_valid, in_sel, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );
  modport slave (
    input  in_valid, in_sel, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
`endif
endinterface

// File: rtl/decoder_pipe_pattern.sv
// Combinational select decoder: onehot / thermometer / inverted onehot, with range
// and reserved-mode error flagging (pattern forced to zero on error).
import decoder_pkg::*;

module decoder_pattern #(
  parameter int SEL_W = 3,
  parameter int OUT_W = 8
) (
  input  logic [SEL_W-1:0] sel,
  input  mode_t            mode,
  output logic [OUT_W-1:0] pattern,
  output logic             err
);

  logic [OUT_W-1:0] onehot;
  logic [OUT_W-1:0] thermo;

  always_comb begin
    onehot = '0;
    thermo = '0;
    for (int i = 0; i < OUT_W; i++) begin
      onehot[i] = (sel == SEL_W'(i));
      thermo[i] = (SEL_W'(i) <= sel);
    end
    // sel is in range exactly when it hits one of the OUT_W bit positions
    err     = ~(|onehot) || (mode == MODE_RSVD);
    pattern = '0;
    if (!err) begin
      case (mode)
        MODE_ONEHOT: pattern = onehot;
        MODE_THERMO: pattern = thermo;
        MODE_INV:    pattern = ~onehot;
        default:     pattern = '0;
      endcase
    end
  end

endmodule

// File: rtl/decoder_pipe.sv
// Registered decoder with a 2-entry skid buffer on the output handshake.
// Define DECODER_PIPE_PARITY_EN to carry an even-parity bit (out_par) with each entry.
import decoder_pkg::*;

// state | meaning
// EMPTY | no beat held, out_valid low
// ONE   | head entry valid, skid entry free
// FULL  | head and skid entries valid, in_ready low
module decoder_pipe #(
  parameter int SEL_W = 3,
  parameter int OUT_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  decoder_pipe_if.slave  bus
);

  localparam logic [1:0] EMPTY = SKID_EMPTY;
  localparam logic [1:0] ONE   = SKID_ONE;
  localparam logic [1:0] FULL  = SKID_FULL;

  logic [1:0]       state_q, state_d;
  logic             in_ready_q;
  logic             in_xfer, out_xfer;
  logic             load_head, shift_head, load_skid;
  logic [OUT_W-1:0] pat;
  logic             pat_err;
  logic [OUT_W-1:0] data0_q, data1_q;
  logic             err0_q, err1_q;

  decoder_pattern #(
    .SEL_W (SEL_W),
    .OUT_W (OUT_W)
  ) u_pattern (
    .sel     (bus.in_sel),
    .mode    (bus.in_mode),
    .pattern (pat),
    .err     (pat_err)
  );

  assign in_xfer  = bus.in_valid && in_ready_q;
  assign out_xfer = (state_q != EMPTY) && bus.out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (in_xfer) state_d = ONE;
      ONE: begin
        if (in_xfer && !out_xfer)      state_d = FULL;
        else if (!in_xfer && out_xfer) state_d = EMPTY;
      end
      FULL:    if (out_xfer) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // new beat goes to the head when the head is free or being drained this cycle
  assign load_head  = in_xfer && ((state_q == EMPTY) || ((state_q == ONE) && out_xfer));
  assign load_skid  = in_xfer && (state_q == ONE) && !out_xfer;
  assign shift_head = (state_q == FULL) && out_xfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
      data0_q    <= '0;
      err0_q     <= 1'b0;
      data1_q    <= '0;
      err1_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
      if (load_head) begin
        data0_q <= pat;
        err0_q  <= pat_err;
      end else if (shift_head) begin
        data0_q <= data1_q;
        err0_q  <= err1_q;
      end
      if (load_skid) begin
        data1_q <= pat;
        err1_q  <= pat_err;
      end
    end
  end

`ifdef DECODER_PIPE_PARITY_EN
  logic par0_q, par1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      par0_q <= 1'b0;
      par1_q <= 1'b0;
    end else begin
      if (load_head)       par0_q <= ^pat;
      else if (shift_head) par0_q <= par1_q;
      if (load_skid)       par1_q <= ^pat;
    end
  end

  assign bus.out_par = par0_q;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.out_data  = data0_q;
  assign bus.out_err   = err0_q;

endmodule

// File: tb/tb_decoder_pipe.sv
// Self-checking bench for decoder_pipe: fixed vector tables, stall/reset sequences and
// randomized traffic against a queue model. Honours DECODER_PIPE_PARITY_EN if defined.
import decoder_pkg::*;

module tb_decoder_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decoder_pipe_if #(.SEL_W(3), .OUT_W(8)) bus8 ();
  decoder_pipe_if #(.SEL_W(3), .OUT_W(5)) bus5 ();

  decoder_pipe #(.SEL_W(3), .OUT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  decoder_pipe #(.SEL_W(3), .OUT_W(5)) dut5 (.clk(clk), .rst(rst), .bus(bus5));

  typedef struct {
    int         mode;
    int         sel;
    logic [7:0] data;
    logic       err;
  } vec_t;

  vec_t t8[13];
  vec_t t5[8];
  logic [8:0] q[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv8(input bit v, input int mode, input int sel);
    bus8.in_valid = v;
    bus8.in_mode  = mode_t'(mode[1:0]);
    bus8.in_sel   = sel[2:0];
  endtask

  task automatic drv5(input bit v, input int mode, input int sel);
    bus5.in_valid = v;
    bus5.in_mode  = mode_t'(mode[1:0]);
    bus5.in_sel   = sel[2:0];
  endtask

  // reference decode from the mode rules, returns {err, data}
  function automatic logic [8:0] ref_dec(input int w, input int mode, input int sel);
    int unsigned d;
    int unsigned mask;
    mask = (1 << w) - 1;
    if (mode == 3 || sel >= w) return {1'b1, 8'h00};
    case (mode)
      0:       d = 1 << sel;
      1:       d = (1 << (sel + 1)) - 1;
      default: d = ~(1 << sel) & mask;
    endcase
    return {1'b0, d[7:0]};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) t8[i] = '{0, i, 8'h00, 1'b0};
    t8[0].data = 8'h01; t8[1].data = 8'h02; t8[2].data = 8'h04; t8[3].data = 8'h08;
    t8[4].data = 8'h10; t8[5].data = 8'h20; t8[6].data = 8'h40; t8[7].data = 8'h80;
    t8[8]  = '{1, 3, 8'h0F, 1'b0};
    t8[9]  = '{2, 3, 8'hF7, 1'b0};
    t8[10] = '{3, 5, 8'h00, 1'b1};
    t8[11] = '{1, 7, 8'hFF, 1'b0};
    t8[12] = '{2, 0, 8'hFE, 1'b0};

    t5[0] = '{0, 6, 8'h00, 1'b1};
    t5[1] = '{0, 4, 8'h10, 1'b0};
    t5[2] = '{0, 5, 8'h00, 1'b1};
    t5[3] = '{1, 4, 8'h1F, 1'b0};
    t5[4] = '{1, 2, 8'h07, 1'b0};
    t5[5] = '{2, 1, 8'h1D, 1'b0};
    t5[6] = '{2, 4, 8'h0F, 1'b0};
    t5[7] = '{3, 0, 8'h00, 1'b1};

    rst = 1'b1;
    drv8(0, 0, 0); bus8.out_ready = 1'b1;
    drv5(0, 0, 0); bus5.out_ready = 1'b1;
    repeat (2) tick();
    chk("rst_valid",  bus8.out_valid, 0);
    chk("rst_ready",  bus8.in_ready,  0);
    chk("rst_data",   bus8.out_data,  0);
    chk("rst_err",    bus8.out_err,   0);
    chk("rst5_valid", bus5.out_valid, 0);
    rst = 1'b0;
    repeat (2) tick();
    chk("post_rst_ready", bus8.in_ready, 1);
    chk("post_rst_valid", bus8.out_valid, 0);

    // back-to-back table, each beat must appear the cycle after it is offered
    for (int i = 0; i <= 13; i++) begin
      if (i < 13) drv8(1, t8[i].mode, t8[i].sel);
      else        drv8(0, 0, 0);
      tick();
      if (i < 13) begin
        chk("t8_valid", bus8.out_valid, 1);
        chk("t8_data",  bus8.out_data,  t8[i].data);
        chk("t8_err",   bus8.out_err,   t8[i].err);
        chk("t8_ready", bus8.in_ready,  1);
`ifdef DECODER_PIPE_PARITY_EN
        chk("t8_par",   bus8.out_par,   ^t8[i].data);
`endif
      end else begin
        chk("t8_drain", bus8.out_valid, 0);
      end
    end

    for (int i = 0; i <= 8; i++) begin
      if (i < 8) drv5(1, t5[i].mode, t5[i].sel);
      else       drv5(0, 0, 0);
      tick();
      if (i < 8) begin
        chk("t5_valid", bus5.out_valid, 1);
        chk("t5_data",  bus5.out_data,  t5[i].data);
        chk("t5_err",   bus5.out_err,   t5[i].err);
      end else begin
        chk("t5_drain", bus5.out_valid, 0);
      end
    end

    // backpressure: two beats accepted, third held off, order and stability kept
    bus8.out_ready = 1'b0;
    drv8(1, 0, 1);
    tick();
    chk("bp_a_valid", bus8.out_valid, 1);
    chk("bp_a_data",  bus8.out_data,  8'h02);
    chk("bp_a_ready", bus8.in_ready,  1);
    drv8(1, 1, 2);
    tick();
    chk("bp_full_ready", bus8.in_ready, 0);
    chk("bp_full_data",  bus8.out_data, 8'h02);
    drv8(1, 2, 4);
    repeat (3) begin
      tick();
      chk("bp_stall_ready", bus8.in_ready,  0);
      chk("bp_stall_valid", bus8.out_valid, 1);
      chk("bp_stall_data",  bus8.out_data,  8'h02);
      chk("bp_stall_err",   bus8.out_err,   0);
    end
    drv8(0, 0, 0);
    bus8.out_ready = 1'b1;
    tick();
    chk("bp_b_valid", bus8.out_valid, 1);
    chk("bp_b_data",  bus8.out_data,  8'h07);
    chk("bp_b_ready", bus8.in_ready,  1);
`ifdef DECODER_PIPE_PARITY_EN
    chk("bp_b_par",   bus8.out_par,   1);
`endif
    repeat (4) begin
      tick();
      chk("bp_no_c", bus8.out_valid, 0);
    end

    // reset while FULL discards both entries
    bus8.out_ready = 1'b0;
    drv8(1, 0, 5);
    tick();
    drv8(1, 0, 6);
    tick();
    chk("rf_full", bus8.in_ready, 0);
    drv8(0, 0, 0);
    rst = 1'b1;
    tick();
    chk("rf_valid", bus8.out_valid, 0);
    chk("rf_data",  bus8.out_data,  0);
    chk("rf_err",   bus8.out_err,   0);
    rst = 1'b0;
    bus8.out_ready = 1'b1;
    repeat (4) begin
      tick();
      chk("rf_no_stale", bus8.out_valid, 0);
    end
    chk("rf_ready", bus8.in_ready, 1);

    // randomized traffic against a 2-deep queue model
    q.delete();
    for (int c = 0; c < 600; c++) begin
      bit v, ordy, in_x, out_x;
      int m, s;
      chk("rnd_valid", bus8.out_valid, (q.size() > 0));
      chk("rnd_ready", bus8.in_ready,  (q.size() < 2));
      if (q.size() > 0) begin
        chk("rnd_data", bus8.out_data, q[0][7:0]);
        chk("rnd_err",  bus8.out_err,  q[0][8]);
`ifdef DECODER_PIPE_PARITY_EN
        chk("rnd_par",  bus8.out_par,  ^q[0][7:0]);
`endif
      end
      v    = ($urandom_range(0, 99) < 70);
      ordy = ($urandom_range(0, 99) < 60);
      m    = $urandom_range(0, 3);
      s    = $urandom_range(0, 7);
      drv8(v, m, s);
      bus8.out_ready = ordy;
      in_x  = v && (q.size() < 2);
      out_x = ordy && (q.size() > 0);
      if (out_x) void'(q.pop_front());
      if (in_x)  q.push_back(ref_dec(8, m, s));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
